// File: rtl/avr_flash_arbiter_pkg.sv
// Shared types and defaults for the AVR program-memory arbiter.
package avr_flash_arbiter_pkg;

    localparam int unsigned AW_DEF       = 9;
    localparam int unsigned DW_DEF       = 16;
    localparam int unsigned BOOT_CYC_DEF = 4;
    localparam int unsigned SUM_W        = 16;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_LPM  = 2'd2,
        ST_LOAD = 2'd3
    } arb_state_e;

    // LPM byte select: bit 0 of the byte address picks the high byte
    function automatic logic [7:0] lpm_byte(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/avr_flash_loader_port.sv
// Loader-side handshake: one access per ack, read-data capture and write checksum.
module avr_flash_loader_port
    import avr_flash_arbiter_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             active_i,
    input  logic             sum_clr_i,
    input  logic             ld_req_i,
    input  logic             ld_we_i,
    input  logic [DW-1:0]    ld_wdata_i,
    input  logic [DW-1:0]    mem_rdata_i,
    output logic             ld_ack_o,
    output logic [DW-1:0]    ld_rdata_o,
    output logic [SUM_W-1:0] ld_sum_o,
    output logic             mem_we_o
);

    logic             ld_ack_q, ld_ack_d;
    logic [DW-1:0]    ld_rdata_q, ld_rdata_d;
    logic [SUM_W-1:0] ld_sum_q, ld_sum_d;
    logic             accept;

    // A request still high during its own ack cycle must not be served twice
    assign accept   = active_i && ld_req_i && !ld_ack_q;
    assign mem_we_o = accept && ld_we_i;

    always_comb begin
        ld_ack_d   = accept;
        ld_rdata_d = ld_rdata_q;
        ld_sum_d   = ld_sum_q;
        if (sum_clr_i) begin
            ld_sum_d = '0;
        end else if (accept && ld_we_i) begin
            ld_sum_d = ld_sum_q + SUM_W'(ld_wdata_i);
        end
        if (accept && !ld_we_i) begin
            ld_rdata_d = mem_rdata_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ld_ack_q   <= 1'b0;
            ld_rdata_q <= '0;
            ld_sum_q   <= '0;
        end else begin
            ld_ack_q   <= ld_ack_d;
            ld_rdata_q <= ld_rdata_d;
            ld_sum_q   <= ld_sum_d;
        end
    end

    assign ld_ack_o   = ld_ack_q;
    assign ld_rdata_o = ld_rdata_q;
    assign ld_sum_o   = ld_sum_q;

endmodule

// File: rtl/avr_flash_arbiter.sv
// Shares AVR program RAM between instruction fetch, LPM reads and the boot loader;
// stalls the core while memory is busy and resets it after every load.
module avr_flash_arbiter
    import avr_flash_arbiter_pkg::*;
#(
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned BOOT_CYC = BOOT_CYC_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [AW-1:0]    cpu_pc,
    output logic [DW-1:0]    cpu_flash,
    output logic             cpu_locked,
    output logic             cpu_reset,
    input  logic             lpm_req,
    input  logic [AW:0]      lpm_addr,
    output logic             lpm_ack,
    output logic [7:0]       lpm_data,
    input  logic             ld_hold,
    input  logic             ld_req,
    input  logic             ld_we,
    input  logic [AW-1:0]    ld_addr,
    input  logic [DW-1:0]    ld_wdata,
    output logic             ld_ack,
    output logic [DW-1:0]    ld_rdata,
    output logic [SUM_W-1:0] ld_sum,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_we,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata
);

    localparam int unsigned   CW          = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;
    localparam logic [CW-1:0] BOOT_RELOAD = CW'(BOOT_CYC - 1);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] boot_cnt_q, boot_cnt_d;
    logic          lpm_ack_q;
    logic [7:0]    lpm_data_q, lpm_data_d;
    logic          load_active;
    logic          sum_clr;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= BOOT_RELOAD;
            lpm_ack_q  <= 1'b0;
            lpm_data_q <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            lpm_ack_q  <= (state_q == ST_LPM);
            lpm_data_q <= lpm_data_d;
        end
    end

    // Next state, address mux and LPM byte capture
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        lpm_data_d = lpm_data_q;
        mem_addr   = '0;
        case (state_q)
            ST_BOOT: begin
                if (ld_hold) begin
                    state_d = ST_LOAD;
                end else if (boot_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q - CW'(1);
                end
            end
            ST_RUN: begin
                mem_addr = cpu_pc;
                if (ld_hold) begin
                    state_d = ST_LOAD;
                end else if (lpm_req && !lpm_ack_q) begin
                    state_d = ST_LPM;
                end
            end
            ST_LPM: begin
                mem_addr   = lpm_addr[AW:1];
                lpm_data_d = lpm_byte(16'(mem_rdata), lpm_addr[0]);
                state_d    = ST_RUN;
            end
            ST_LOAD: begin
                mem_addr = ld_addr;
                if (!ld_hold) begin
                    state_d    = ST_BOOT;
                    boot_cnt_d = BOOT_RELOAD;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // New accesses only while the loader still holds memory; reset aborts the access
    assign load_active = (state_q == ST_LOAD) && ld_hold && !reset;
    assign sum_clr     = (state_q != ST_LOAD) && (state_d == ST_LOAD);

    avr_flash_loader_port #(
        .DW(DW)
    ) u_loader_port (
        .clock      (clock),
        .reset      (reset),
        .active_i   (load_active),
        .sum_clr_i  (sum_clr),
        .ld_req_i   (ld_req),
        .ld_we_i    (ld_we),
        .ld_wdata_i (ld_wdata),
        .mem_rdata_i(mem_rdata),
        .ld_ack_o   (ld_ack),
        .ld_rdata_o (ld_rdata),
        .ld_sum_o   (ld_sum),
        .mem_we_o   (mem_we)
    );

    assign mem_wdata  = ld_wdata;
    assign cpu_flash  = mem_rdata;
    assign cpu_locked = (state_q == ST_RUN);
    assign cpu_reset  = (state_q == ST_BOOT);
    assign lpm_ack    = lpm_ack_q;
    assign lpm_data   = lpm_data_q;

endmodule

// File: tb/tb_avr_flash_arbiter.sv
// Directed bench for avr_flash_arbiter with a behavioural program RAM.
module tb_avr_flash_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [8:0]  cpu_pc;
    logic [15:0] cpu_flash;
    logic        cpu_locked, cpu_reset;
    logic        lpm_req;
    logic [9:0]  lpm_addr;
    logic        lpm_ack;
    logic [7:0]  lpm_data;
    logic        ld_hold, ld_req, ld_we;
    logic [8:0]  ld_addr;
    logic [15:0] ld_wdata;
    logic        ld_ack;
    logic [15:0] ld_rdata, ld_sum;
    logic [8:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata, mem_rdata;

    logic [15:0] mem [512];
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clock) if (mem_we) mem[mem_addr] <= mem_wdata;

    avr_flash_arbiter dut (
        .clock(clock), .reset(reset),
        .cpu_pc(cpu_pc), .cpu_flash(cpu_flash), .cpu_locked(cpu_locked), .cpu_reset(cpu_reset),
        .lpm_req(lpm_req), .lpm_addr(lpm_addr), .lpm_ack(lpm_ack), .lpm_data(lpm_data),
        .ld_hold(ld_hold), .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_ack(ld_ack), .ld_rdata(ld_rdata), .ld_sum(ld_sum),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Counts cycles with cpu_reset high, bounded so a stuck BOOT cannot hang the run
    task automatic count_boot(input string name);
        int n = 0;
        while (cpu_reset === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        checks++;
        if (n != 4) begin errors++; $display("FAIL %s boot_len got %0d exp 4", name, n); end
        checks++;
        if (cpu_locked !== 1'b1) begin errors++; $display("FAIL %s locked_after_boot got %b exp 1", name, cpu_locked); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset got %b exp 1", cpu_reset); end
        checks++;
        if (cpu_locked !== 1'b0) begin errors++; $display("FAIL rst_locked got %b exp 0", cpu_locked); end
        checks++;
        if ({lpm_ack, ld_ack, lpm_data, ld_rdata, ld_sum} !== 42'd0) begin
            errors++; $display("FAIL rst_outputs got %h exp 0", {lpm_ack, ld_ack, lpm_data, ld_rdata, ld_sum});
        end
        checks++;
        if (mem_addr !== 9'h000) begin errors++; $display("FAIL rst_mem_addr got %h exp 000", mem_addr); end
        count_boot("reset");
        cpu_pc = 9'h055;
        #1;
        checks++;
        if (mem_addr !== 9'h055) begin errors++; $display("FAIL run_mem_addr got %h exp 055", mem_addr); end
        checks++;
        if (cpu_flash !== 16'hBEEF) begin errors++; $display("FAIL run_cpu_flash got %h exp BEEF", cpu_flash); end
    endtask

    task automatic test_lpm(input logic [9:0] addr, input logic [7:0] exp_byte);
        lpm_req  = 1'b1;
        lpm_addr = addr;
        tick();
        checks++;
        if (cpu_locked !== 1'b0) begin errors++; $display("FAIL lpm_locked got %b exp 0", cpu_locked); end
        checks++;
        if (mem_addr !== 9'h012) begin errors++; $display("FAIL lpm_mem_addr got %h exp 012", mem_addr); end
        checks++;
        if (lpm_ack !== 1'b0) begin errors++; $display("FAIL lpm_ack_early got %b exp 0", lpm_ack); end
        tick();
        checks++;
        if (lpm_ack !== 1'b1) begin errors++; $display("FAIL lpm_ack got %b exp 1", lpm_ack); end
        checks++;
        if (lpm_data !== exp_byte) begin errors++; $display("FAIL lpm_data got %h exp %h", lpm_data, exp_byte); end
        checks++;
        if (cpu_locked !== 1'b1) begin errors++; $display("FAIL lpm_relock got %b exp 1", cpu_locked); end
        // Request still high during the ack cycle must not start another read
        tick();
        lpm_req = 1'b0;
        checks++;
        if (cpu_locked !== 1'b1 || lpm_ack !== 1'b0) begin
            errors++; $display("FAIL lpm_no_reserve got locked=%b ack=%b exp locked=1 ack=0", cpu_locked, lpm_ack);
        end
        tick();
    endtask

    task automatic test_ld_ignored_in_run();
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 9'h005; ld_wdata = 16'h9999;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL run_ld_we got %b exp 0", mem_we); end
        tick();
        tick();
        checks++;
        if (ld_ack !== 1'b0) begin errors++; $display("FAIL run_ld_ack got %b exp 0", ld_ack); end
        ld_req = 1'b0;
        checks++;
        if (mem[5] !== 16'h0000) begin errors++; $display("FAIL run_ld_mem got %h exp 0000", mem[5]); end
    endtask

    task automatic test_load_write();
        ld_hold = 1'b1;
        tick();
        checks++;
        if (cpu_locked !== 1'b0 || cpu_reset !== 1'b0) begin
            errors++; $display("FAIL load_entry got locked=%b rst=%b exp 0 0", cpu_locked, cpu_reset);
        end
        checks++;
        if (ld_sum !== 16'h0000) begin errors++; $display("FAIL load_sum_clr got %h exp 0000", ld_sum); end
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 9'h000; ld_wdata = 16'hFFFF;
        #1;
        checks++;
        if (mem_we !== 1'b1) begin errors++; $display("FAIL wr0_we got %b exp 1", mem_we); end
        tick();
        checks++;
        if (ld_ack !== 1'b1) begin errors++; $display("FAIL wr0_ack got %b exp 1", ld_ack); end
        checks++;
        if (mem[0] !== 16'hFFFF) begin errors++; $display("FAIL wr0_mem got %h exp FFFF", mem[0]); end
        ld_addr = 9'h001; ld_wdata = 16'h0003;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL wr1_we_in_ack got %b exp 0", mem_we); end
        tick();
        checks++;
        if (ld_ack !== 1'b0 || mem_we !== 1'b1) begin
            errors++; $display("FAIL wr1_issue got ack=%b we=%b exp 0 1", ld_ack, mem_we);
        end
        tick();
        ld_req = 1'b0;
        checks++;
        if (ld_ack !== 1'b1) begin errors++; $display("FAIL wr1_ack got %b exp 1", ld_ack); end
        checks++;
        if (mem[1] !== 16'h0003) begin errors++; $display("FAIL wr1_mem got %h exp 0003", mem[1]); end
        checks++;
        if (ld_sum !== 16'h0002) begin errors++; $display("FAIL wr_sum got %h exp 0002", ld_sum); end
        tick();
    endtask

    task automatic test_load_read();
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 9'h1FF; ld_wdata = 16'hAAAA;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL rd_we got %b exp 0", mem_we); end
        tick();
        ld_req = 1'b0;
        checks++;
        if (ld_ack !== 1'b1) begin errors++; $display("FAIL rd_ack got %b exp 1", ld_ack); end
        checks++;
        if (ld_rdata !== 16'h1234) begin errors++; $display("FAIL rd_data got %h exp 1234", ld_rdata); end
        checks++;
        if (ld_sum !== 16'h0002) begin errors++; $display("FAIL rd_sum got %h exp 0002", ld_sum); end
        tick();
        ld_hold = 1'b0;
        tick();
        checks++;
        if (ld_sum !== 16'h0002) begin errors++; $display("FAIL sum_held got %h exp 0002", ld_sum); end
        count_boot("load_exit");
    endtask

    task automatic test_hold_vs_lpm();
        ld_hold = 1'b1;
        lpm_req = 1'b1;
        lpm_addr = 10'h025;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (lpm_ack !== 1'b0 || cpu_locked !== 1'b0) begin
                errors++; $display("FAIL prio_cycle%0d got ack=%b locked=%b exp 0 0", i, lpm_ack, cpu_locked);
            end
        end
        checks++;
        if (ld_sum !== 16'h0000) begin errors++; $display("FAIL prio_sum_clr got %h exp 0000", ld_sum); end
        lpm_req = 1'b0;
        ld_hold = 1'b0;
        tick();
        count_boot("prio_exit");
    endtask

    task automatic test_reset_mid_load();
        ld_hold = 1'b1;
        tick();
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 9'h005; ld_wdata = 16'h7777;
        reset = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL rstld_we got %b exp 0", mem_we); end
        tick();
        reset = 1'b0;
        ld_req = 1'b0;
        ld_hold = 1'b0;
        checks++;
        if (ld_ack !== 1'b0 || ld_sum !== 16'h0000) begin
            errors++; $display("FAIL rstld_ack_sum got ack=%b sum=%h exp 0 0000", ld_ack, ld_sum);
        end
        checks++;
        if (cpu_reset !== 1'b1 || cpu_locked !== 1'b0) begin
            errors++; $display("FAIL rstld_boot got rst=%b locked=%b exp 1 0", cpu_reset, cpu_locked);
        end
        checks++;
        if (mem[5] !== 16'h0000) begin errors++; $display("FAIL rstld_mem got %h exp 0000", mem[5]); end
        tick();
        checks++;
        if (ld_ack !== 1'b0) begin errors++; $display("FAIL rstld_late_ack got %b exp 0", ld_ack); end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
        mem[9'h012] = 16'hA55A;
        mem[9'h055] = 16'hBEEF;
        mem[9'h1FF] = 16'h1234;
        reset = 1'b1; cpu_pc = '0; lpm_req = 1'b0; lpm_addr = '0;
        ld_hold = 1'b0; ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
        test_reset();
        test_lpm(10'h025, 8'hA5);
        test_lpm(10'h024, 8'h5A);
        test_ld_ignored_in_run();
        test_load_write();
        test_load_read();
        test_hold_vs_lpm();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
